// File: rtl/alu_cu_pkg.sv
// Shared opcode values, FSM state encoding and opcode classification for the ALU control unit.
// Optional illegal-opcode trap is selected in the top by ALU_CU_ILLEGAL_TRAP_EN.
package alu_cu_pkg;

   localparam logic [5:0] OP_ADD = 6'b010000;
   localparam logic [5:0] OP_SUB = 6'b010001;
   localparam logic [5:0] OP_SLL = 6'b110000;
   localparam logic [5:0] OP_SRL = 6'b110001;
   localparam logic [5:0] OP_SRA = 6'b110010;
   localparam logic [5:0] OP_EQ  = 6'b100000;
   localparam logic [5:0] OP_NEQ = 6'b100001;
   localparam logic [5:0] OP_LE  = 6'b100010;
   localparam logic [5:0] OP_GT  = 6'b100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_TRAP    = 2'd3
   } state_t;

   // Compare opcodes write back the single-bit ALU result instead of the word result.
   function automatic logic is_cmp(input logic [5:0] op);
      case (op)
         OP_EQ, OP_NEQ, OP_LE, OP_GT: is_cmp = 1'b1;
         default:                     is_cmp = 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: is_legal = 1'b1;
         default:                                is_legal = is_cmp(op);
      endcase
   endfunction

endpackage

// File: rtl/alu_cu_regfile.sv
// Register file: two operand read ports plus a debug read port, all combinational;
// two write ports where the CAPTURE write-back beats a host write to the same index.
module alu_cu_regfile
   import alu_cu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   input  logic [REG_AW-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd2_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              cap_wr_en,
   input  logic [REG_AW-1:0] cap_wr_addr,
   input  logic [DATA_W-1:0] cap_wr_data,
   input  logic              host_wr_en,
   input  logic [REG_AW-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data
);

   localparam int DEPTH = 1 << REG_AW;

   logic [DATA_W-1:0] words [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DATA_W-1:0] word_q;
         logic [DATA_W-1:0] word_d;

         always_comb begin
            word_d = word_q;
            if (cap_wr_en && (cap_wr_addr == REG_AW'(gi))) begin
               word_d = cap_wr_data;
            end else if (host_wr_en && (host_wr_addr == REG_AW'(gi))) begin
               word_d = host_wr_data;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign words[gi] = word_q;
      end
   endgenerate

   assign rd1_data = words[rd1_addr];
   assign rd2_data = words[rd2_addr];
   assign dbg_data = words[dbg_addr];

endmodule

// File: rtl/alu_control_unit.sv
// ALU control unit: accepts one instruction, drives the ALU, writes the result back.
// Define ALU_CU_ILLEGAL_TRAP_EN to trap on unlisted opcodes; otherwise they retire as NOPs.
module alu_control_unit
   import alu_cu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [6+3*REG_AW-1:0] instr,
   input  logic                  reg_wr_en,
   input  logic [REG_AW-1:0]     reg_wr_addr,
   input  logic [DATA_W-1:0]     reg_wr_data,
   input  logic [REG_AW-1:0]     dbg_rd_addr,
   output logic [DATA_W-1:0]     dbg_rd_data,
   output logic [5:0]            alu_op,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   input  logic [DATA_W-1:0]     alu_ans1,
   input  logic                  alu_ans2,
   input  logic                  alu_z,
   input  logic                  alu_n,
   output logic                  done,
   output logic [DATA_W-1:0]     result,
   output logic                  flag_z,
   output logic                  flag_n,
   output logic                  illegal
);

   localparam int INSTR_W = 6 + 3 * REG_AW;

   logic [5:0]        instr_op;
   logic [REG_AW-1:0] instr_rd;
   logic [REG_AW-1:0] instr_rs1;
   logic [REG_AW-1:0] instr_rs2;

   assign instr_op  = instr[INSTR_W-1 -: 6];
   assign instr_rd  = instr[3*REG_AW-1 -: REG_AW];
   assign instr_rs1 = instr[2*REG_AW-1 -: REG_AW];
   assign instr_rs2 = instr[REG_AW-1:0];

   state_t            state_q,   state_d;
   logic [5:0]        alu_op_q,  alu_op_d;
   logic [DATA_W-1:0] alu_a_q,   alu_a_d;
   logic [DATA_W-1:0] alu_b_q,   alu_b_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic              done_q,    done_d;
   logic [DATA_W-1:0] result_q,  result_d;
   logic              flag_z_q,  flag_z_d;
   logic              flag_n_q,  flag_n_d;
   logic              illegal_q, illegal_d;

   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              wb_en;
   logic [DATA_W-1:0] wb_data;

   alu_cu_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd1_addr     (instr_rs1),
      .rd1_data     (rs1_data),
      .rd2_addr     (instr_rs2),
      .rd2_data     (rs2_data),
      .dbg_addr     (dbg_rd_addr),
      .dbg_data     (dbg_rd_data),
      .cap_wr_en    (wb_en),
      .cap_wr_addr  (rd_q),
      .cap_wr_data  (wb_data),
      .host_wr_en   (reg_wr_en),
      .host_wr_addr (reg_wr_addr),
      .host_wr_data (reg_wr_data)
   );

   assign wb_data = is_cmp(alu_op_q) ? {{(DATA_W-1){1'b0}}, alu_ans2} : alu_ans1;

   always_comb begin
      state_d   = state_q;
      alu_op_d  = alu_op_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      rd_d      = rd_q;
      done_d    = 1'b0;
      result_d  = result_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      illegal_d = illegal_q;
      wb_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Operands come from the pre-edge register contents, so a coincident host write is not seen.
            if (instr_valid) begin
               state_d  = ST_ISSUE;
               alu_op_d = instr_op;
               rd_d     = instr_rd;
               alu_a_d  = rs1_data;
               alu_b_d  = rs2_data;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (is_legal(alu_op_q)) begin
               wb_en    = 1'b1;
               result_d = wb_data;
               flag_z_d = alu_z;
               flag_n_d = alu_n;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
`ifdef ALU_CU_ILLEGAL_TRAP_EN
               illegal_d = 1'b1;
               state_d   = ST_TRAP;
`else
               done_d  = 1'b1;
               state_d = ST_IDLE;
`endif
            end
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         alu_op_q  <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         rd_q      <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_op_q  <= alu_op_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         rd_q      <= rd_d;
         done_q    <= done_d;
         result_q  <= result_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
         illegal_q <= illegal_d;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign done        = done_q;
   assign result      = result_q;
   assign flag_z      = flag_z_q;
   assign flag_n      = flag_n_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: behavioural ALU on the alu_* ports, directed table, corner sequences, random traffic.
module tb_alu_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [14:0] instr;
   logic        reg_wr_en;
   logic [2:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic [2:0]  dbg_rd_addr;
   logic [31:0] dbg_rd_data;
   logic [5:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_ans1;
   logic        alu_ans2;
   logic        alu_z;
   logic        alu_n;
   logic        done;
   logic [31:0] result;
   logic        flag_z;
   logic        flag_n;
   logic        illegal;

   always #5 clk = ~clk;

   alu_control_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .dbg_rd_addr (dbg_rd_addr),
      .dbg_rd_data (dbg_rd_data),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ans1    (alu_ans1),
      .alu_ans2    (alu_ans2),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .done        (done),
      .result      (result),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .illegal     (illegal)
   );

   typedef struct packed {
      logic [31:0] ans1;
      logic        ans2;
      logic        z;
      logic        n;
   } alu_res_t;

   function automatic alu_res_t alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_res_t r;
      logic [32:0] sum;
      r = '0;
      case (op)
         6'b010000: begin sum = {1'b0, a} + {1'b0, b}; r.ans1 = sum[31:0]; r.ans2 = sum[32]; end
         6'b010001: begin r.ans1 = a - b; r.ans2 = (a < b); end
         6'b110000: r.ans1 = a << b[4:0];
         6'b110001: r.ans1 = a >> b[4:0];
         6'b110010: r.ans1 = $unsigned($signed(a) >>> b[4:0]);
         6'b100000: begin r.ans1 = a - b; r.ans2 = (a == b); end
         6'b100001: begin r.ans1 = a - b; r.ans2 = (a != b); end
         6'b100010: begin r.ans1 = a - b; r.ans2 = (a <= b); end
         6'b100011: begin r.ans1 = a - b; r.ans2 = (a > b); end
         default:   r.ans1 = 32'h0;
      endcase
      r.z = (r.ans1 == 32'h0);
      r.n = r.ans1[31];
      return r;
   endfunction

   alu_res_t alu_res;
   assign alu_res  = alu_fn(alu_op, alu_a, alu_b);
   assign alu_ans1 = alu_res.ans1;
   assign alu_ans2 = alu_res.ans2;
   assign alu_z    = alu_res.z;
   assign alu_n    = alu_res.n;

   // Reference state: register contents and last-retired result/flags.
   logic [31:0] m_regs [8];
   logic [31:0] m_res;
   logic        m_z;
   logic        m_n;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic tb_is_cmp(input logic [5:0] op);
      return op inside {6'b100000, 6'b100001, 6'b100010, 6'b100011};
   endfunction

   function automatic logic tb_is_legal(input logic [5:0] op);
      return tb_is_cmp(op) || (op inside {6'b010000, 6'b010001, 6'b110000, 6'b110001, 6'b110010});
   endfunction

   // Applies the model's view of one retired instruction.
   task automatic model_retire(input logic [5:0] op, input logic [2:0] rd, input logic [31:0] a, input logic [31:0] b);
      alu_res_t r;
      logic [31:0] wb;
      r  = alu_fn(op, a, b);
      wb = tb_is_cmp(op) ? {31'b0, r.ans2} : r.ans1;
      if (tb_is_legal(op)) begin
         m_regs[rd] = wb;
         m_res      = wb;
         m_z        = r.z;
         m_n        = r.n;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_res = 32'h0;
      m_z   = 1'b0;
      m_n   = 1'b0;
   endtask

   task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      reg_wr_en   = 1'b1;
      reg_wr_addr = addr;
      reg_wr_data = data;
      @(posedge clk);
      #1;
      reg_wr_en = 1'b0;
      m_regs[addr] = data;
      $display("host  write r%0d = %h", addr, data);
   endtask

   task automatic check_all_regs(input string name);
      for (int i = 0; i < 8; i++) begin
         dbg_rd_addr = 3'(i);
         #1;
         chk(name, dbg_rd_data, m_regs[i]);
      end
   endtask

   // Issues one instruction, checks operand latch, retire latency, result, flags and rd.
   task automatic run_instr(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      int          w;
      int          lat;
      int          exp_lat;
      exp_a = m_regs[rs1];
      exp_b = m_regs[rs2];
      @(negedge clk);
      w = 0;
      while (!instr_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (w == 10) chk("ready_timeout", 32'(instr_ready), 32'd1);
      instr       = {op, rd, rs1, rs2};
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
`ifdef ALU_CU_ILLEGAL_TRAP_EN
      exp_lat = tb_is_legal(op) ? 2 : 0;
`else
      exp_lat = 2;
`endif
      chk("latency", 32'(lat), 32'(exp_lat));
      model_retire(op, rd, exp_a, exp_b);
      chk("result", result, m_res);
      chk("flag_z", 32'(flag_z), 32'(m_z));
      chk("flag_n", 32'(flag_n), 32'(m_n));
      dbg_rd_addr = rd;
      #1;
      chk("rd_value", dbg_rd_data, m_regs[rd]);
      $display("instr op=%b rd=r%0d rs1=r%0d rs2=r%0d a=%h b=%h -> result=%h z=%0b n=%0b lat=%0d",
               op, rd, rs1, rs2, exp_a, exp_b, result, flag_z, flag_n, lat);
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [31:0] exp_res;
      logic        exp_z;
      logic        exp_n;
   } vec_t;

   vec_t vecs[7];

   logic [5:0] legal_ops[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int dn;
      int low;
      logic [31:0] old_r1;
      logic [31:0] ea;
      logic [31:0] eb;

      legal_ops = '{6'b010000, 6'b010001, 6'b110000, 6'b110001, 6'b110010,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011};

      // Directed vectors, with r1=0x11, r2=0x1, r6=0xFFFFFFFF preloaded.
      vecs[0] = '{6'b010000, 3'd3, 3'd1, 3'd2, 32'h0000_0012, 1'b0, 1'b0}; // ADD r3,r1,r2
      vecs[1] = '{6'b010001, 3'd4, 3'd1, 3'd1, 32'h0000_0000, 1'b1, 1'b0}; // SUB r4,r1,r1
      vecs[2] = '{6'b010001, 3'd5, 3'd2, 3'd1, 32'hFFFF_FFF0, 1'b0, 1'b1}; // SUB r5,r2,r1
      vecs[3] = '{6'b100011, 3'd7, 3'd6, 3'd2, 32'h0000_0001, 1'b0, 1'b1}; // GT r7,r6,r2
      vecs[4] = '{6'b100000, 3'd7, 3'd2, 3'd2, 32'h0000_0001, 1'b1, 1'b0}; // EQ r7,r2,r2
      vecs[5] = '{6'b110000, 3'd0, 3'd1, 3'd2, 32'h0000_0022, 1'b0, 1'b0}; // SLL r0,r1,r2
      vecs[6] = '{6'b100001, 3'd0, 3'd1, 3'd1, 32'h0000_0000, 1'b1, 1'b0}; // NEQ r0,r1,r1

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      reg_wr_en   = 1'b0;
      reg_wr_addr = '0;
      reg_wr_data = '0;
      dbg_rd_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_alu_op", 32'(alu_op), 32'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);
      chk("rst_flags", {30'b0, flag_z, flag_n}, 32'h0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      check_all_regs("rst_regs");

      host_write(3'd1, 32'h11);
      host_write(3'd2, 32'h1);
      host_write(3'd6, 32'hFFFF_FFFF);

      for (int i = 0; i < 7; i++) begin
         run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
         chk("tbl_result", result, vecs[i].exp_res);
         chk("tbl_flag_z", 32'(flag_z), 32'(vecs[i].exp_z));
         chk("tbl_flag_n", 32'(flag_n), 32'(vecs[i].exp_n));
      end

      // Back-to-back: valid held high, 3 accepts and 3 retires in 9 cycles.
      @(negedge clk);
      instr       = {6'b010000, 3'd3, 3'd1, 3'd2};
      instr_valid = 1'b1;
      acc = 0; dn = 0; low = 0;
      for (int k = 0; k < 9; k++) begin
         if (instr_ready && instr_valid) acc++;
         @(posedge clk);
         #1;
         if (done) dn++;
         if (!instr_ready) low++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_retires", 32'(dn), 32'd3);
      chk("b2b_ready_low", 32'(low), 32'd6);
      model_retire(6'b010000, 3'd3, m_regs[1], m_regs[2]);
      dbg_rd_addr = 3'd3;
      #1;
      chk("b2b_r3", dbg_rd_data, m_regs[3]);
      $display("b2b   accepts=%0d retires=%0d ready_low=%0d", acc, dn, low);

      // Host write colliding with CAPTURE write-back to r3: write-back wins.
      @(negedge clk);
      instr       = {6'b010001, 3'd3, 3'd6, 3'd1};
      instr_valid = 1'b1;
      ea = m_regs[6];
      eb = m_regs[1];
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reg_wr_en   = 1'b1;
      reg_wr_addr = 3'd3;
      reg_wr_data = 32'hAA;
      @(posedge clk);
      #1;
      reg_wr_en = 1'b0;
      chk("collide_done", 32'(done), 32'd1);
      model_retire(6'b010001, 3'd3, ea, eb);
      dbg_rd_addr = 3'd3;
      #1;
      chk("collide_r3", dbg_rd_data, m_regs[3]);
      $display("coll  r3=%h (host wrote 000000aa)", dbg_rd_data);

      // Host write to r1 on the acceptance edge is not seen by that instruction.
      @(negedge clk);
      old_r1      = m_regs[1];
      instr       = {6'b010000, 3'd4, 3'd1, 3'd2};
      instr_valid = 1'b1;
      reg_wr_en   = 1'b1;
      reg_wr_addr = 3'd1;
      reg_wr_data = 32'h55;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      reg_wr_en   = 1'b0;
      m_regs[1]   = 32'h55;
      chk("accwr_alu_a", alu_a, old_r1);
      repeat (2) @(posedge clk);
      #1;
      chk("accwr_done", 32'(done), 32'd1);
      model_retire(6'b010000, 3'd4, old_r1, m_regs[2]);
      check_all_regs("accwr_regs");
      $display("accwr r4=%h r1=%h", m_regs[4], m_regs[1]);

      // Random traffic against the model.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 3) begin
            host_write(3'($urandom_range(0, 7)), $urandom());
         end else begin
            run_instr(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         end
      end
      check_all_regs("rand_regs");

      // Reset asserted while the instruction is in ISSUE.
      @(negedge clk);
      instr       = {6'b010000, 3'd5, 3'd1, 3'd2};
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      dn = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      model_reset();
      chk("rstmid_no_done", 32'(dn), 32'd0);
      chk("rstmid_result", result, 32'h0);
      chk("rstmid_ready", 32'(instr_ready), 32'd1);
      check_all_regs("rstmid_regs");
      $display("rstmid done_count=%0d", dn);

      // Unlisted opcode 000111.
      host_write(3'd1, 32'h0000_0123);
      host_write(3'd2, 32'h0000_0004);
      run_instr(6'b010000, 3'd3, 3'd1, 3'd2);
      run_instr(6'b000111, 3'd3, 3'd1, 3'd2);
      check_all_regs("illop_regs");
`ifdef ALU_CU_ILLEGAL_TRAP_EN
      chk("illop_illegal", 32'(illegal), 32'd1);
      chk("illop_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("illop_rst_illegal", 32'(illegal), 32'd0);
      chk("illop_rst_ready", 32'(instr_ready), 32'd1);
`else
      chk("illop_illegal", 32'(illegal), 32'd0);
      chk("illop_ready", 32'(instr_ready), 32'd1);
`endif
      $display("illop illegal=%0b ready=%0b", illegal, instr_ready);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
